// File: rtl/fifo_pack_pkg.sv
// Shared helpers for the width-converting packing FIFO (optional flush: FIFO_PACK_FLUSH_EN).
// Holds the pointer/counter width helper and the lane mirroring used for MSB-first packing.
package fifo_pack_pkg;

    function automatic int unsigned ptr_w(input int unsigned n);
        return (n <= 32'd2) ? 32'd1 : $clog2(n);
    endfunction

    // Mirroring is its own inverse, so it maps logical->physical and back.
    function automatic int unsigned lane_idx(input int unsigned idx,
                                             input int unsigned ratio,
                                             input int unsigned msb_first);
        return (msb_first != 32'd0) ? (ratio - 32'd1 - idx) : idx;
    endfunction

endpackage

// File: rtl/fifo_pack_packer.sv
// Lane assembler: collects RATIO narrow words and emits a one-cycle push strobe with the packed word.
// With FIFO_PACK_FLUSH_EN a partial word can be pushed early; a flush against full storage waits in flush_pend.
module fifo_pack_packer
    import fifo_pack_pkg::*;
#(
    parameter int unsigned IN_W      = 8,
    parameter int unsigned RATIO     = 2,
    parameter int unsigned MSB_FIRST = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IN_W-1:0]       data_in,
    input  logic                  input_valid,
    input  logic                  full,
`ifdef FIFO_PACK_FLUSH_EN
    input  logic                  flush,
    output logic [RATIO-1:0]      push_keep,
`endif
    output logic                  input_enable,
    output logic                  push,
    output logic [IN_W*RATIO-1:0] push_word
);
    localparam int unsigned CNT_W = ptr_w(RATIO);
    localparam int unsigned FIL_W = ptr_w(RATIO + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(RATIO - 1);

    logic [RATIO-1:0][IN_W-1:0] lanes_q, lanes_d;
    logic [CNT_W-1:0]           lane_cnt_q, lane_cnt_d;
    logic                       flush_pend_q, flush_pend_d;
    logic                       accept, complete;
    logic [FIL_W-1:0]           filled;
    logic [RATIO-1:0]           keep;

    assign input_enable = ((lane_cnt_q != LAST) | ~full) & ~flush_pend_q;

    // Lane fill, keep mask, push strobe and next-state for the counter / pending flush
    always_comb begin
        accept       = input_valid & input_enable;
        complete     = accept & (lane_cnt_q == LAST);
        filled       = FIL_W'(lane_cnt_q) + FIL_W'(accept);
        lanes_d      = lanes_q;
        keep         = '0;
        push_word    = '0;
        push         = 1'b0;
        flush_pend_d = 1'b0;
        for (int i = 0; i < int'(RATIO); i++) begin
            if (accept && (lane_idx(32'(lane_cnt_q), RATIO, MSB_FIRST) == 32'(i))) begin
                lanes_d[i] = data_in;
            end else begin
                lanes_d[i] = lanes_q[i];
            end
            keep[i] = (lane_idx(32'(i), RATIO, MSB_FIRST) < 32'(filled));
            push_word[i*IN_W +: IN_W] = keep[i] ? lanes_d[i] : '0;
        end
        if (complete) begin
            push       = 1'b1;
            lane_cnt_d = '0;
        end else if (accept) begin
            lane_cnt_d = lane_cnt_q + CNT_W'(1);
        end else begin
            lane_cnt_d = lane_cnt_q;
        end
`ifdef FIFO_PACK_FLUSH_EN
        push_keep = keep;
        // A completing accept already pushes the word, so a same-cycle flush has nothing left to do.
        if ((flush | flush_pend_q) && !complete && (filled != '0)) begin
            if (full) begin
                flush_pend_d = 1'b1;
            end else begin
                push       = 1'b1;
                lane_cnt_d = '0;
            end
        end else begin
            flush_pend_d = 1'b0;
        end
`endif
    end

    // Packer state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            lanes_q      <= '0;
            lane_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            lanes_q      <= lanes_d;
            lane_cnt_q   <= lane_cnt_d;
            flush_pend_q <= flush_pend_d;
        end
    end

endmodule

// File: rtl/fifo_pack.sv
// Width-converting FIFO: packs RATIO IN_W-bit words and buffers DEPTH packed words (show-ahead read).
// Define FIFO_PACK_FLUSH_EN to add the flush input, per-entry keep masks and the data_keep output.
module fifo_pack
    import fifo_pack_pkg::*;
#(
    parameter int unsigned IN_W      = 8,
    parameter int unsigned RATIO     = 2,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MSB_FIRST = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [IN_W-1:0]              data_in,
    input  logic                         input_valid,
    output logic                         input_enable,
    output logic [IN_W*RATIO-1:0]        data_out,
    output logic                         output_valid,
    input  logic                         output_enable,
`ifdef FIFO_PACK_FLUSH_EN
    input  logic                         flush,
    output logic [RATIO-1:0]             data_keep,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   level
);
    localparam int unsigned DW    = IN_W * RATIO;
    localparam int unsigned PTR_W = ptr_w(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    logic [DW-1:0]    mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             full, pop, push;
    logic [DW-1:0]    push_word;

    assign full         = (level_q == LVL_W'(DEPTH));
    assign output_valid = (level_q != '0);
    assign pop          = output_valid & output_enable;
    assign level        = level_q;
    assign data_out     = output_valid ? mem_q[rd_ptr_q] : '0;

`ifdef FIFO_PACK_FLUSH_EN
    logic [RATIO-1:0] keep_mem_q [DEPTH];
    logic [RATIO-1:0] push_keep;

    assign data_keep = output_valid ? keep_mem_q[rd_ptr_q] : '0;

    // Keep masks travel alongside their words; like the data they are not cleared by reset
    always_ff @(posedge clk) begin
        if (push) begin
            keep_mem_q[wr_ptr_q] <= push_keep;
        end
    end
`endif

    fifo_pack_packer #(
        .IN_W      (IN_W),
        .RATIO     (RATIO),
        .MSB_FIRST (MSB_FIRST)
    ) u_packer (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .input_valid  (input_valid),
        .full         (full),
`ifdef FIFO_PACK_FLUSH_EN
        .flush        (flush),
        .push_keep    (push_keep),
`endif
        .input_enable (input_enable),
        .push         (push),
        .push_word    (push_word)
    );

    // Pointer and occupancy next-state; pointers wrap naturally since DEPTH is a power of two
    always_comb begin
        wr_ptr_d = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Storage array write port
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

    // Pointer and level registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule
